// File: rtl/fifo_drain_ctrl.sv
// fifo_drain_ctrl: pops one word at a time from a FIFO read port and hands it to a serializer.
// Build option FIFO_DRAIN_CNT_EN adds the 16-bit delivered-word counter drain_cnt.
//
// state     | meaning
// IDLE      | waiting for a non-empty FIFO and an idle serializer
// SEND      | word presented on tx_p_data, waiting for tx_busy (bounded by BUSY_TIMEOUT)
// WAIT_DONE | serializer busy with the word, waiting for it to finish
module fifo_drain_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  tx_busy,
  output logic                  rinc,
  output logic [DATA_WIDTH-1:0] tx_p_data,
  output logic                  tx_data_valid,
  output logic                  timeout_err
`ifdef FIFO_DRAIN_CNT_EN
  ,
  output logic [15:0]           drain_cnt
`endif
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_SEND      = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;

  localparam logic [7:0] TIMER_LAST = 8'(BUSY_TIMEOUT - 1);

  logic [1:0] state;
  logic [7:0] timer;

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state         <= ST_IDLE;
      timer         <= 8'd0;
      rinc          <= 1'b0;
      tx_p_data     <= '0;
      tx_data_valid <= 1'b0;
      timeout_err   <= 1'b0;
`ifdef FIFO_DRAIN_CNT_EN
      drain_cnt     <= 16'd0;
`endif
    end else begin
      // rinc is a one-cycle pulse; only the IDLE->SEND transition raises it
      rinc <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!rempty && !tx_busy) begin
            tx_p_data     <= rdata;
            rinc          <= 1'b1;
            tx_data_valid <= 1'b1;
            timer         <= 8'd0;
            state         <= ST_SEND;
          end
        end
        ST_SEND: begin
          // busy takes priority over the timeout in the last SEND cycle
          if (tx_busy) begin
            tx_data_valid <= 1'b0;
            state         <= ST_WAIT_DONE;
`ifdef FIFO_DRAIN_CNT_EN
            drain_cnt     <= drain_cnt + 16'd1;
`endif
          end else if (timer == TIMER_LAST) begin
            tx_data_valid <= 1'b0;
            timeout_err   <= 1'b1;
            state         <= ST_IDLE;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        ST_WAIT_DONE: begin
          if (!tx_busy) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Directed bench for fifo_drain_ctrl (default parameters); drain_cnt checks apply when
// FIFO_DRAIN_CNT_EN is defined.
module tb_fifo_drain_ctrl;

  logic       rclk;
  logic       rrst;
  logic       rempty;
  logic [7:0] rdata;
  logic       tx_busy;
  logic       rinc;
  logic [7:0] tx_p_data;
  logic       tx_data_valid;
  logic       timeout_err;
`ifdef FIFO_DRAIN_CNT_EN
  logic [15:0] drain_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int rinc_pulses = 0;

  fifo_drain_ctrl #(.DATA_WIDTH(8), .BUSY_TIMEOUT(16)) dut (
    .rclk          (rclk),
    .rrst          (rrst),
    .rempty        (rempty),
    .rdata         (rdata),
    .tx_busy       (tx_busy),
    .rinc          (rinc),
    .tx_p_data     (tx_p_data),
    .tx_data_valid (tx_data_valid),
    .timeout_err   (timeout_err)
`ifdef FIFO_DRAIN_CNT_EN
    ,
    .drain_cnt     (drain_cnt)
`endif
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  always @(negedge rclk) if (rinc === 1'b1) rinc_pulses++;

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic apply_reset();
    rrst = 1'b1; rempty = 1'b1; tx_busy = 1'b0; rdata = 8'h00;
    step();
    rrst = 1'b0;
  endtask

  task automatic test_reset();
    rrst = 1'b1; rempty = 1'b0; tx_busy = 1'b0; rdata = 8'hEE;
    step(); step();
    checks++; if (rinc !== 1'b0) begin errors++; $display("FAIL reset_rinc got %b exp 0", rinc); end
    checks++; if (tx_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", tx_data_valid); end
    checks++; if (tx_p_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", tx_p_data); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", timeout_err); end
`ifdef FIFO_DRAIN_CNT_EN
    checks++; if (drain_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", drain_cnt); end
`endif
    rrst = 1'b0; rempty = 1'b1;
  endtask

  task automatic test_single_word();
    int base;
    base = rinc_pulses;
    rempty = 1'b0; rdata = 8'hA5; tx_busy = 1'b0;
    step();
    checks++; if (rinc !== 1'b1 || tx_data_valid !== 1'b1) begin errors++; $display("FAIL single_start got rinc=%b valid=%b exp 1 1", rinc, tx_data_valid); end
    checks++; if (tx_p_data !== 8'hA5) begin errors++; $display("FAIL single_data got %h exp a5", tx_p_data); end
    rempty = 1'b1; rdata = 8'h00;
    step();
    checks++; if (rinc !== 1'b0 || tx_data_valid !== 1'b1) begin errors++; $display("FAIL single_send2 got rinc=%b valid=%b exp 0 1", rinc, tx_data_valid); end
    tx_busy = 1'b1;
    step();
    checks++; if (tx_data_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop got %b exp 0", tx_data_valid); end
    checks++; if (tx_p_data !== 8'hA5) begin errors++; $display("FAIL single_data_hold got %h exp a5", tx_p_data); end
    step();
    tx_busy = 1'b0;
    step(); step();
    checks++; if (rinc_pulses - base !== 1) begin errors++; $display("FAIL single_pulses got %0d exp 1", rinc_pulses - base); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [3];
    int base;
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    apply_reset();
    base = rinc_pulses;
    for (int w = 0; w < 3; w++) begin
      rempty = 1'b0; rdata = words[w]; tx_busy = 1'b0;
      step();
      checks++; if (rinc !== 1'b1 || tx_p_data !== words[w]) begin errors++; $display("FAIL b2b_start%0d got rinc=%b data=%h exp 1 %h", w, rinc, tx_p_data, words[w]); end
      rempty = 1'b1; rdata = 8'hFF;
      step();
      tx_busy = 1'b1;
      for (int c = 0; c < 10; c++) step();
      checks++; if (tx_data_valid !== 1'b0 || rinc !== 1'b0 || tx_p_data !== words[w]) begin
        errors++; $display("FAIL b2b_busy%0d got valid=%b rinc=%b data=%h exp 0 0 %h", w, tx_data_valid, rinc, tx_p_data, words[w]);
      end
      tx_busy = 1'b0;
      step();
    end
    step();
    checks++; if (rinc_pulses - base !== 3) begin errors++; $display("FAIL b2b_pulses got %0d exp 3", rinc_pulses - base); end
`ifdef FIFO_DRAIN_CNT_EN
    checks++; if (drain_cnt !== 16'd3) begin errors++; $display("FAIL b2b_cnt got %0d exp 3", drain_cnt); end
`endif
  endtask

  task automatic test_busy_at_limit();
    apply_reset();
    rempty = 1'b0; rdata = 8'h3C; tx_busy = 1'b0;
    step();
    rempty = 1'b1;
    for (int i = 1; i <= 15; i++) step();
    checks++; if (tx_data_valid !== 1'b1 || timeout_err !== 1'b0) begin errors++; $display("FAIL limit_cycle16 got valid=%b err=%b exp 1 0", tx_data_valid, timeout_err); end
    tx_busy = 1'b1;
    step();
    checks++; if (tx_data_valid !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL limit_busy_wins got valid=%b err=%b exp 0 0", tx_data_valid, timeout_err); end
    step();
    tx_busy = 1'b0;
    step(); step();
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL limit_err_after got %b exp 0", timeout_err); end
`ifdef FIFO_DRAIN_CNT_EN
    checks++; if (drain_cnt !== 16'd1) begin errors++; $display("FAIL limit_cnt got %0d exp 1", drain_cnt); end
`endif
  endtask

  task automatic test_timeout();
    int base;
`ifdef FIFO_DRAIN_CNT_EN
    logic [15:0] cnt0;
    cnt0 = drain_cnt;
`endif
    base = rinc_pulses;
    rempty = 1'b0; rdata = 8'hC3; tx_busy = 1'b0;
    step();
    rempty = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      step();
      checks++; if (tx_data_valid !== 1'b1 || timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_wait%0d got valid=%b err=%b exp 1 0", i, tx_data_valid, timeout_err); end
    end
    step();
    checks++; if (tx_data_valid !== 1'b0 || timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_fire got valid=%b err=%b exp 0 1", tx_data_valid, timeout_err); end
    step(); step();
`ifdef FIFO_DRAIN_CNT_EN
    checks++; if (drain_cnt !== cnt0) begin errors++; $display("FAIL timeout_cnt got %0d exp %0d", drain_cnt, cnt0); end
`endif
    // a later successful word must not clear the sticky flag
    rempty = 1'b0; rdata = 8'h5A;
    step();
    rempty = 1'b1;
    step();
    tx_busy = 1'b1;
    step();
    tx_busy = 1'b0;
    step(); step();
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky got %b exp 1", timeout_err); end
    checks++; if (rinc_pulses - base !== 2) begin errors++; $display("FAIL timeout_pulses got %0d exp 2", rinc_pulses - base); end
  endtask

  task automatic test_reset_mid_send();
    rempty = 1'b0; rdata = 8'h77; tx_busy = 1'b0;
    step();
    rempty = 1'b1;
    step();
    rrst = 1'b1;
    step();
    checks++; if (rinc !== 1'b0 || tx_data_valid !== 1'b0 || tx_p_data !== 8'h00 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs got rinc=%b valid=%b data=%h err=%b exp 0 0 00 0", rinc, tx_data_valid, tx_p_data, timeout_err);
    end
`ifdef FIFO_DRAIN_CNT_EN
    checks++; if (drain_cnt !== 16'd0) begin errors++; $display("FAIL midrst_cnt got %0d exp 0", drain_cnt); end
`endif
    rrst = 1'b0; rempty = 1'b0; rdata = 8'h88;
    step();
    checks++; if (rinc !== 1'b1 || tx_data_valid !== 1'b1 || tx_p_data !== 8'h88) begin
      errors++; $display("FAIL midrst_restart got rinc=%b valid=%b data=%h exp 1 1 88", rinc, tx_data_valid, tx_p_data);
    end
    rempty = 1'b1;
    step();
    tx_busy = 1'b1;
    step();
    tx_busy = 1'b0;
    step(); step();
  endtask

  task automatic test_busy_in_idle();
    rempty = 1'b0; rdata = 8'h99; tx_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (rinc !== 1'b0 || tx_data_valid !== 1'b0) begin errors++; $display("FAIL idlebusy_hold%0d got rinc=%b valid=%b exp 0 0", i, rinc, tx_data_valid); end
    end
    tx_busy = 1'b0;
    step();
    checks++; if (rinc !== 1'b1 || tx_data_valid !== 1'b1 || tx_p_data !== 8'h99) begin
      errors++; $display("FAIL idlebusy_start got rinc=%b valid=%b data=%h exp 1 1 99", rinc, tx_data_valid, tx_p_data);
    end
    rempty = 1'b1;
    step();
    checks++; if (rinc !== 1'b0) begin errors++; $display("FAIL idlebusy_pulse got %b exp 0", rinc); end
    tx_busy = 1'b1;
    step();
    tx_busy = 1'b0;
    step(); step();
  endtask

  initial begin
    rrst = 1'b1; rempty = 1'b1; rdata = 8'h00; tx_busy = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_busy_at_limit();
    test_timeout();
    test_reset_mid_send();
    test_busy_in_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
